// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and encodings for the pipeline hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  typedef enum logic [1:0] {INIT, RUN, BUSY} hz_state_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  // clear wins over increment; increment is suppressed once saturated
  always_ff @(posedge clk_i)
    cnt_o <= (rst || clr_i) ? '0 : cnt_o + WIDTH'(inc_i && !(&cnt_o));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch hazards, multi-cycle op sequencing and perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MC_LATENCY = 4,
  parameter int RST_FLUSH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1D_i,
  input  logic [ADDR_WIDTH-1:0] rs2D_i,
  input  logic [ADDR_WIDTH-1:0] rs1E_i,
  input  logic [ADDR_WIDTH-1:0] rs2E_i,
  input  logic [ADDR_WIDTH-1:0] rdE_i,
  input  logic [ADDR_WIDTH-1:0] rdM_i,
  input  logic [ADDR_WIDTH-1:0] rdW_i,
  input  logic                  reg_writeM_i,
  input  logic                  reg_writeW_i,
  input  logic [1:0]            result_srcE_i,
  input  logic                  pc_srcE_i,
  input  logic                  mc_startE_i,
  input  logic                  clr_cnt_i,
  output logic [1:0]            forward_aE_o,
  output logic [1:0]            forward_bE_o,
  output logic                  stallF_o,
  output logic                  stallD_o,
  output logic                  stallE_o,
  output logic                  flushD_o,
  output logic                  flushE_o,
  output logic                  flushM_o,
  output logic                  mc_done_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);
  localparam int CMAX = (RST_FLUSH - 1 > MC_LATENCY - 2) ? RST_FLUSH - 1 : MC_LATENCY - 2;
  localparam int CW = CMAX > 0 ? $clog2(CMAX + 1) : 1;
  if (MC_LATENCY < 2) begin : g_bad_mc
    $error("hazard_ctrl: MC_LATENCY must be >= 2");
  end
  if (RST_FLUSH < 1) begin : g_bad_rf
    $error("hazard_ctrl: RST_FLUSH must be >= 1");
  end
  hz_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          run, lw_stall, br_flush, mc_stall;
  function automatic fwd_sel_t fwd(input logic [ADDR_WIDTH-1:0] rs);
    return (reg_writeM_i && rdM_i != '0 && rdM_i == rs) ? FWD_MEM :
           (reg_writeW_i && rdW_i != '0 && rdW_i == rs) ? FWD_WB : FWD_RF;
  endfunction
  // one counter serves both the post-reset flush window and the multi-cycle countdown
  always_ff @(posedge clk_i)
    if (rst) begin
      state <= INIT;
      cnt   <= CW'(RST_FLUSH - 1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // hazard decode and next-state; everything except flushD/E is silenced during reset
  always_comb begin
    run          = !rst && state == RUN;
    lw_stall     = run && result_srcE_i == RESULT_LOAD && rdE_i != '0 &&
                   (rdE_i == rs1D_i || rdE_i == rs2D_i);
    br_flush     = run && pc_srcE_i;
    mc_stall     = (run && mc_startE_i) || (!rst && state == BUSY && cnt != '0);
    mc_done_o    = !rst && state == BUSY && cnt == '0;
    stallF_o     = lw_stall || mc_stall;
    stallD_o     = lw_stall || mc_stall;
    stallE_o     = mc_stall;
    flushM_o     = mc_stall;
    flushD_o     = rst || state == INIT || br_flush;
    flushE_o     = rst || state == INIT || br_flush || lw_stall;
    forward_aE_o = rst ? FWD_RF : fwd(rs1E_i);
    forward_bE_o = rst ? FWD_RF : fwd(rs2E_i);
    state_n      = state == INIT ? (cnt == '0 ? RUN : INIT) :
                   state == RUN  ? (mc_startE_i ? BUSY : RUN) :
                                   (cnt == '0 ? RUN : BUSY);
    cnt_n        = state == RUN ? CW'(MC_LATENCY - 2) : (cnt == '0 ? cnt : cnt - 1'b1);
  end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i (clk_i),
    .rst   (rst),
    .inc_i (stallF_o),
    .clr_i (clr_cnt_i),
    .cnt_o (stall_cnt_o)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i (clk_i),
    .rst   (rst),
    .inc_i (br_flush),
    .clr_i (clr_cnt_i),
    .cnt_o (flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: model-checked bench over three parameterisations of hazard_ctrl
module tb_hazard_ctrl;
  localparam int N = 3;
  localparam int RSTF = 2;
  localparam int MCL [N] = '{4, 2, 4};
  localparam int CWS [N] = '{16, 16, 4};
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic rwM, rwW, pc, mc, clr;
  logic [1:0] rsrc;
  logic [1:0] fa [N];
  logic [1:0] fb [N];
  logic sf [N], sd [N], se [N], fd [N], fe [N], fm [N], md [N];
  logic [15:0] sc [N], fc [N];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [CWS[g]-1:0] s, f;
    hazard_ctrl #(.ADDR_WIDTH(5), .MC_LATENCY(MCL[g]), .RST_FLUSH(RSTF), .CNT_WIDTH(CWS[g])) dut (
      .clk_i(clk), .rst(rst), .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
      .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW), .reg_writeM_i(rwM), .reg_writeW_i(rwW),
      .result_srcE_i(rsrc), .pc_srcE_i(pc), .mc_startE_i(mc), .clr_cnt_i(clr),
      .forward_aE_o(fa[g]), .forward_bE_o(fb[g]), .stallF_o(sf[g]), .stallD_o(sd[g]),
      .stallE_o(se[g]), .flushD_o(fd[g]), .flushE_o(fe[g]), .flushM_o(fm[g]),
      .mc_done_o(md[g]), .stall_cnt_o(s), .flush_cnt_o(f)
    );
    assign sc[g] = 16'(s);
    assign fc[g] = 16'(f);
  end
  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, md, br;
  } exp_t;
  int init_left [N], mc_left [N], scnt [N], fcnt [N];
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%0d expected=%0d", name, k, $time, act, exp);
    end
  endtask
  function automatic logic [1:0] fwd_m(input logic [4:0] rs);
    if (rwM && rdM != 0 && rdM == rs) return 2'b10;
    if (rwW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic exp_t model(input int k);
    exp_t e;
    logic lw;
    e = '0;
    if (rst) begin
      e.fd = 1'b1;
      e.fe = 1'b1;
      return e;
    end
    e.fa = fwd_m(rs1E);
    e.fb = fwd_m(rs2E);
    if (init_left[k] > 0) begin
      e.fd = 1'b1;
      e.fe = 1'b1;
    end else if (mc_left[k] > 0) begin
      e.sf = mc_left[k] > 1;
      e.sd = e.sf;
      e.se = e.sf;
      e.fm = e.sf;
      e.md = mc_left[k] == 1;
    end else begin
      lw = rsrc == 2'b01 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      e.sf = lw | mc;
      e.sd = lw | mc;
      e.se = mc;
      e.fm = mc;
      e.br = pc;
      e.fd = pc;
      e.fe = pc | lw;
    end
    return e;
  endfunction
  exp_t eu, ec;
  always @(posedge clk)
    for (int k = 0; k < N; k++) begin
      eu = model(k);
      if (rst) begin
        init_left[k] = RSTF;
        mc_left[k] = 0;
        scnt[k] = 0;
        fcnt[k] = 0;
      end else begin
        if (clr) begin
          scnt[k] = 0;
          fcnt[k] = 0;
        end else begin
          if (eu.sf && scnt[k] < (1 << CWS[k]) - 1) scnt[k]++;
          if (eu.br && fcnt[k] < (1 << CWS[k]) - 1) fcnt[k]++;
        end
        if (init_left[k] > 0) init_left[k]--;
        else if (mc_left[k] > 0) mc_left[k]--;
        else if (mc) mc_left[k] = MCL[k] - 1;
      end
    end
  always @(negedge clk)
    for (int k = 0; k < N; k++) begin
      ec = model(k);
      chk("forward_aE", k, 32'(fa[k]), 32'(ec.fa));
      chk("forward_bE", k, 32'(fb[k]), 32'(ec.fb));
      chk("stallF", k, 32'(sf[k]), 32'(ec.sf));
      chk("stallD", k, 32'(sd[k]), 32'(ec.sd));
      chk("stallE", k, 32'(se[k]), 32'(ec.se));
      chk("flushD", k, 32'(fd[k]), 32'(ec.fd));
      chk("flushE", k, 32'(fe[k]), 32'(ec.fe));
      chk("flushM", k, 32'(fm[k]), 32'(ec.fm));
      chk("mc_done", k, 32'(md[k]), 32'(ec.md));
      chk("stall_cnt", k, 32'(sc[k]), 32'(scnt[k]));
      chk("flush_cnt", k, 32'(fc[k]), 32'(fcnt[k]));
    end
  always @(negedge clk)
    if (!rst) assert (!(pc && rsrc == 2'b01 && rdE != 0)) else $error("stimulus drives branch and load in E together");
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {rwM, rwW, pc, mc, clr} = '0;
    rsrc = 2'b00;
    rst = 1'b1;
    pc = 1'b1;
    rs1E = 5'd5;
    rdM = 5'd5;
    rwM = 1'b1;
    tick(); #2;
    chk("lit_rst_fwd", 0, 32'(fa[0]), 0);
    chk("lit_rst_flushD", 0, 32'(fd[0]), 1);
    chk("lit_rst_stallF", 0, 32'(sf[0]), 0);
    tick(); rst = 1'b0; #2;
    chk("lit_init1_flushD", 0, 32'(fd[0]), 1);
    tick(); #2;
    chk("lit_init2_flushE", 0, 32'(fe[0]), 1);
    chk("lit_init_fwd", 0, 32'(fa[0]), 2);
    tick(); pc = 1'b0; #2;
    chk("lit_run_flushD", 0, 32'(fd[0]), 0);
    chk("lit_init_flush_cnt", 0, 32'(fc[0]), 0);
    rdW = 5'd5; rwW = 1'b1; #1;
    chk("lit_fwd_mem_prio", 0, 32'(fa[0]), 2);
    tick(); rdM = 5'd0; #2;
    chk("lit_fwd_wb", 0, 32'(fa[0]), 1);
    tick(); rwW = 1'b0; #2;
    chk("lit_fwd_rf", 0, 32'(fa[0]), 0);
    tick(); rs2E = 5'd0; rdM = 5'd0; rdW = 5'd0; rwM = 1'b1; rwW = 1'b1; #2;
    chk("lit_fwd_b_x0", 0, 32'(fb[0]), 0);
    tick(); rs2E = 5'd3; rdW = 5'd3; #2;
    chk("lit_fwd_b_wb", 0, 32'(fb[0]), 1);
    tick(); {rs1E, rs2E, rdM, rdW} = '0; {rwM, rwW} = '0;
    rsrc = 2'b01; rdE = 5'd7; rs2D = 5'd7; #2;
    chk("lit_lw_stallF", 0, 32'(sf[0]), 1);
    chk("lit_lw_stallD", 0, 32'(sd[0]), 1);
    chk("lit_lw_flushE", 0, 32'(fe[0]), 1);
    chk("lit_lw_flushD", 0, 32'(fd[0]), 0);
    tick(); rsrc = 2'b00; rdE = 5'd0; rs2D = 5'd0; #2;
    chk("lit_lw_stall_cnt", 0, 32'(sc[0]), 1);
    chk("lit_lw_one_bubble", 0, 32'(sf[0]), 0);
    tick(); rsrc = 2'b01; #2;
    chk("lit_lw_x0", 0, 32'(sf[0]), 0);
    tick(); rsrc = 2'b00; pc = 1'b1; #2;
    chk("lit_br_flushD", 0, 32'(fd[0]), 1);
    chk("lit_br_flushE", 0, 32'(fe[0]), 1);
    chk("lit_br_stallF", 0, 32'(sf[0]), 0);
    tick(); pc = 1'b0; #2;
    chk("lit_br_flush_cnt", 0, 32'(fc[0]), 1);
    tick(); mc = 1'b1; #2;
    chk("lit_mc_a_stallE", 0, 32'(se[0]), 1);
    chk("lit_mc_a_flushM", 0, 32'(fm[0]), 1);
    tick(); mc = 1'b0; #2;
    chk("lit_mc_b_stallF", 0, 32'(sf[0]), 1);
    chk("lit_mc2_b_done", 1, 32'(md[1]), 1);
    chk("lit_mc2_b_stallF", 1, 32'(sf[1]), 0);
    tick(); pc = 1'b1; #2;
    chk("lit_mc_c_stallF", 0, 32'(sf[0]), 1);
    chk("lit_mc_c_pc_ignored", 0, 32'(fd[0]), 0);
    chk("lit_mc2_c_pc_flush", 1, 32'(fd[1]), 1);
    tick(); pc = 1'b0; #2;
    chk("lit_mc_d_stallF", 0, 32'(sf[0]), 0);
    chk("lit_mc_d_done", 0, 32'(md[0]), 1);
    tick(); #2;
    chk("lit_mc_e_done", 0, 32'(md[0]), 0);
    chk("lit_mc_stall_cnt", 0, 32'(sc[0]), 4);
    chk("lit_mc2_stall_cnt", 1, 32'(sc[1]), 2);
    chk("lit_mc2_flush_cnt", 1, 32'(fc[1]), 2);
    tick(); mc = 1'b1; #2;
    tick(); mc = 1'b0; #2;
    tick(); rst = 1'b1; #2;
    chk("lit_abort_done", 0, 32'(md[0]), 0);
    chk("lit_abort_flushD", 0, 32'(fd[0]), 1);
    chk("lit_abort_stallF", 0, 32'(sf[0]), 0);
    tick(); rst = 1'b0; #2;
    chk("lit_abort_init", 0, 32'(fd[0]), 1);
    chk("lit_abort_cnt_zero", 0, 32'(sc[0]), 0);
    tick(); #2;
    chk("lit_abort_init2", 0, 32'(fd[0]), 1);
    chk("lit_abort_no_done", 0, 32'(md[0]), 0);
    tick(); #2;
    chk("lit_abort_run", 0, 32'(fd[0]), 0);
    tick(); rsrc = 2'b01; rdE = 5'd9; rs1D = 5'd9;
    repeat (20) tick();
    #2;
    chk("lit_sat_cnt16", 0, 32'(sc[0]), 20);
    chk("lit_sat_cnt4", 2, 32'(sc[2]), 15);
    clr = 1'b1;
    tick(); clr = 1'b0; #2;
    chk("lit_clr_cnt16", 0, 32'(sc[0]), 0);
    chk("lit_clr_cnt4", 2, 32'(sc[2]), 0);
    tick(); #2;
    chk("lit_clr_resume", 2, 32'(sc[2]), 1);
    rsrc = 2'b00; rdE = 5'd0; rs1D = 5'd0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and pipeline-control unit for the 5-stage core (F/D/E/M/W).
- Generates operand-forwarding selects for the E-stage ALU inputs.
- Stalls F/D on load-use hazards and flushes D/E on taken branches and jumps.
- Sequences a parametrised multi-cycle execute operation (mul/div) with a busy FSM.
- Holds the pipeline flushed for a fixed window after reset, and keeps saturating stall/flush performance counters.

Parameters:
ADDR_WIDTH, 5, register-address width
MC_LATENCY, 4, total E-stage cycles of a multi-cycle op; must be >= 2 (elaboration error otherwise)
RST_FLUSH, 2, cycles D/E are flushed after reset deasserts; must be >= 1
CNT_WIDTH, 16, width of each performance counter

Ports:
clk_i  in  1  clock
rst  in  1  reset, synchronous, active-high
rs1D_i  in  ADDR_WIDTH  source reg 1 of instruction in D
rs2D_i  in  ADDR_WIDTH  source reg 2 of instruction in D
rs1E_i  in  ADDR_WIDTH  source reg 1 in E
rs2E_i  in  ADDR_WIDTH  source reg 2 in E
rdE_i  in  ADDR_WIDTH  destination in E
rdM_i  in  ADDR_WIDTH  destination in M
rdW_i  in  ADDR_WIDTH  destination in W
reg_writeM_i  in  1  M writes register file
reg_writeW_i  in  1  W writes register file
result_srcE_i  in  2  result select in E (2'b01 = load)
pc_srcE_i  in  1  taken branch/jump resolved in E
mc_startE_i  in  1  E holds a multi-cycle op (level; valid in first E cycle)
clr_cnt_i  in  1  synchronous clear of performance counters
forward_aE_o  out  2  ALU op1 select: 00 regfile, 01 W result, 10 M ALU result
forward_bE_o  out  2  ALU op2 select, same encoding
stallF_o  out  1  hold PC
stallD_o  out  1  hold F/D register
stallE_o  out  1  hold D/E register
flushD_o  out  1  clear F/D register
flushE_o  out  1  clear D/E register
flushM_o  out  1  insert bubble into E/M register
mc_done_o  out  1  one-cycle pulse, multi-cycle result valid in E
stall_cnt_o  out  CNT_WIDTH  cycles with stallF_o high
flush_cnt_o  out  CNT_WIDTH  cycles with pc_srcE flush

Behaviour:
- Forwarding is combinational.
  - forward_aE = 10 if reg_writeM && rdM!=0 && rdM==rs1E.
  - Else 01 if reg_writeW && rdW!=0 && rdW==rs1E.
  - Else 00. M has priority over W.
  - forward_bE is identical, using rs2E.
- Load-use: lw_stall = state==RUN && result_srcE==01 && rdE!=0 && (rdE==rs1D || rdE==rs2D).
  - Effect: stallF=stallD=1 and flushE=1, giving exactly one bubble.
- Branch: in RUN, pc_srcE forces flushD=flushE=1.
  - pc_srcE and lw_stall are mutually exclusive, because E cannot be both load and branch. The bench asserts this.
- FSM states: INIT, RUN, BUSY.
  - rst: state=INIT, init counter=RST_FLUSH-1, perf counters=0.
  - All outputs deassert during rst except flushD=flushE=1.
  - INIT: flushD=flushE=1, no stalls. Counter decrements; at 0, go to RUN next cycle. Total flushed cycles after rst falls = RST_FLUSH.
  - RUN, mc_startE=1: go to BUSY, mc counter=MC_LATENCY-2. In that cycle stallF=stallD=stallE=1 and flushM=1; forwarding still valid.
  - BUSY: stallF/D/E=1 and flushM=1 while counter!=0; counter decrements.
  - BUSY, counter==0: stalls deassert, mc_done_o=1, go to RUN.
  - E occupancy of a multi-cycle op = MC_LATENCY cycles.
  - pc_srcE, lw_stall and mc_startE are ignored in BUSY and INIT.
- rst asserted mid-BUSY aborts the op immediately: no mc_done pulse, state=INIT.
- Counters:
  - stall_cnt +1 per cycle stallF_o=1.
  - flush_cnt +1 per cycle pc_srcE causes a flush; INIT flushes are not counted.
  - Both saturate at all-ones and never wrap.
  - clr_cnt_i zeroes both next cycle and has priority over increment.
- Registered outputs: state, counters. All others are combinational from state and inputs.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - RESULT_LOAD=2'b01.
  - hz_state_t enum (INIT, RUN, BUSY).
- One sub-module, sat_counter (WIDTH, inc_i, clr_i, rst), instantiated twice for the perf counters.

Test Plan:
- Forward priority: rs1E=5, rdM=5, rdW=5, both write → forward_aE=10. rdM=0 → 01. reg_writeW=0 → 00. rs2E=0, rdM=0, writes=1 → forward_bE=00.
- Load-use: result_srcE=01, rdE=7, rs2D=7 → stallF=stallD=flushE=1 for one cycle, stall_cnt 0→1. rdE=0 → no stall.
- Branch: pc_srcE=1 in RUN → flushD=flushE=1, no stall, flush_cnt 0→1.
- Multi-cycle: MC_LATENCY=4, mc_startE pulse → stallF/D/E and flushM high 3 cycles, mc_done high on 4th, stall_cnt=3. Repeat with MC_LATENCY=2 → 1 stall cycle.
- Reset: RST_FLUSH=2 → flushD/E high during rst and 2 cycles after. pc_srcE in those cycles leaves flush_cnt=0. rst during BUSY → no mc_done, INIT re-entered.
- Saturation/clear: CNT_WIDTH=4, hold lw_stall 20 cycles → stall_cnt=15. clr_cnt_i with simultaneous stall → 0 next cycle.
